// File: rtl/hoist_ctrl.sv
// hoist_ctrl: four-state hoist motor controller with stepped position
// tracking, hard limits at 0 and POS_MAX, and an emergency halt.
`timescale 1ns/1ps
module hoist_ctrl #(
   parameter int POS_MAX     = 15,
   parameter int POS_W       = 4,
   parameter int STEP_CYCLES = 4
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             go_up,
   input  logic             go_down,
   input  logic             halt,
   output logic             motor_up,
   output logic             motor_down,
   output logic [POS_W-1:0] pos,
   output logic             top_lim,
   output logic             bott_lim
);

   localparam int STEP_W =
      (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

   localparam logic [POS_W-1:0]  PMAX = POS_W'(POS_MAX);
   localparam logic [POS_W-1:0]  PONE = POS_W'(1);
   localparam logic [STEP_W-1:0] LAST = STEP_W'(STEP_CYCLES - 1);
   localparam logic [STEP_W-1:0] SONE = STEP_W'(1);

   typedef enum logic [1:0] {
      IDLE,
      MOVING_UP,
      MOVING_DOWN,
      HALTED
   } state_t;

   state_t             state_q, state_d;
   logic [POS_W-1:0]   pos_q, pos_d;
   logic [STEP_W-1:0]  step_q, step_d;

   logic up_only;
   logic down_only;

   assign up_only   = go_up & ~go_down;
   assign down_only = go_down & ~go_up;

   // state, position and step registers; reset aborts any pending step
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= IDLE;
         pos_q   <= '0;
         step_q  <= '0;
      end else begin
         state_q <= state_d;
         pos_q   <= pos_d;
         step_q  <= step_d;
      end
   end

   // next state: halt wins, then limits, reversal and step timing
   always_comb begin
      state_d = state_q;
      pos_d   = pos_q;
      step_d  = '0;
      if (halt) begin
         state_d = HALTED;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (up_only && pos_q < PMAX)
                  state_d = MOVING_UP;
               else if (down_only && pos_q != '0)
                  state_d = MOVING_DOWN;
            end
            MOVING_UP: begin
               if (down_only || pos_q >= PMAX) begin
                  state_d = IDLE;
               end else if (step_q == LAST) begin
                  pos_d = pos_q + PONE;
                  if (pos_q + PONE == PMAX)
                     state_d = IDLE;
               end else begin
                  step_d = step_q + SONE;
               end
            end
            MOVING_DOWN: begin
               if (up_only || pos_q == '0) begin
                  state_d = IDLE;
               end else if (step_q == LAST) begin
                  pos_d = pos_q - PONE;
                  if (pos_q == PONE)
                     state_d = IDLE;
               end else begin
                  step_d = step_q + SONE;
               end
            end
            HALTED: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   assign motor_up   = (state_q == MOVING_UP);
   assign motor_down = (state_q == MOVING_DOWN);
   assign pos        = pos_q;
   assign top_lim    = (pos_q == PMAX);
   assign bott_lim   = (pos_q == '0);

endmodule

// File: tb/tb_hoist_ctrl.sv
// tb_hoist_ctrl: directed stimulus with a queued scoreboard checked
// by an independent monitor on the falling clock edge.
`timescale 1ns/1ps
module tb_hoist_ctrl;

   logic       CLK = 1'b0;
   logic       RESET;
   logic       go_up;
   logic       go_down;
   logic       halt;
   logic       motor_up;
   logic       motor_down;
   logic [3:0] pos;
   logic       top_lim;
   logic       bott_lim;

   hoist_ctrl #(
      .POS_MAX(15),
      .POS_W(4),
      .STEP_CYCLES(4)
   ) dut (
      .CLK(CLK),
      .RESET(RESET),
      .go_up(go_up),
      .go_down(go_down),
      .halt(halt),
      .motor_up(motor_up),
      .motor_down(motor_down),
      .pos(pos),
      .top_lim(top_lim),
      .bott_lim(bott_lim)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      string      name;
      int         at;
      logic [7:0] vec;
   } exp_t;

   exp_t q[$];
   int   edges = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   // rising-edge counter used to time-stamp expectations
   always @(posedge CLK) edges = edges + 1;

   task automatic expect_at(input string name, input int n,
                            input logic mu, input logic md,
                            input logic [3:0] p);
      exp_t e;
      e.name = name;
      e.at   = edges + n;
      e.vec  = {mu, md, p, (p == 4'd15), (p == 4'd0)};
      q.push_back(e);
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge CLK);
      #1;
   endtask

   // monitor: compares due expectations and motor exclusivity
   initial begin
      exp_t       e;
      logic [7:0] act;
      forever begin
         @(negedge CLK);
         act = {motor_up, motor_down, pos, top_lim, bott_lim};
         n_cmp = n_cmp + 1;
         if (motor_up && motor_down) begin
            n_bad = n_bad + 1;
            $display("FAIL motor_overlap edge=%0d got up=%b down=%b want not both",
                     edges, motor_up, motor_down);
         end
         while (q.size() > 0 && q[0].at <= edges) begin
            e = q.pop_front();
            n_cmp = n_cmp + 1;
            if (e.at != edges || act !== e.vec) begin
               n_bad = n_bad + 1;
               $display("FAIL %s edge=%0d due=%0d got mu/md/pos/top/bot=%b/%b/%0d/%b/%b want %b/%b/%0d/%b/%b",
                        e.name, edges, e.at,
                        act[7], act[6], act[5:2], act[1], act[0],
                        e.vec[7], e.vec[6], e.vec[5:2], e.vec[1], e.vec[0]);
            end
         end
      end
   end

   // stimulus
   initial begin
      RESET = 1'b1;
      go_up = 1'b1;
      go_down = 1'b0;
      halt = 1'b0;
      wait_n(1);
      expect_at("reset_hold", 1, 0, 0, 0);
      wait_n(1);

      RESET = 1'b0;
      expect_at("up_after_rst", 1, 1, 0, 0);
      expect_at("up_pre_step", 4, 1, 0, 0);
      expect_at("up_first_step", 5, 1, 0, 1);
      expect_at("up_pos14", 60, 1, 0, 14);
      expect_at("up_top_stop", 61, 0, 0, 15);
      wait_n(61);

      expect_at("top_req_up1", 1, 0, 0, 15);
      expect_at("top_req_up2", 2, 0, 0, 15);
      wait_n(2);
      go_down = 1'b1;
      expect_at("both_idle", 1, 0, 0, 15);
      wait_n(1);

      go_up = 1'b0;
      expect_at("dn_entry", 1, 0, 1, 15);
      expect_at("dn_first_step", 5, 0, 1, 14);
      expect_at("dn_pos1", 60, 0, 1, 1);
      expect_at("dn_bott_stop", 61, 0, 0, 0);
      wait_n(1);
      go_down = 1'b0;
      wait_n(60);

      go_down = 1'b1;
      expect_at("bott_req_down", 1, 0, 0, 0);
      wait_n(1);
      go_down = 1'b0;

      go_up = 1'b1;
      expect_at("halt_pre_pos5", 21, 1, 0, 5);
      expect_at("halt_pre_step2", 23, 1, 0, 5);
      wait_n(23);
      halt = 1'b1;
      expect_at("halted", 1, 0, 0, 5);
      wait_n(1);
      halt = 1'b0;
      go_up = 1'b0;
      expect_at("halt_release", 1, 0, 0, 5);
      wait_n(1);
      go_up = 1'b1;
      expect_at("reentry", 1, 1, 0, 5);
      expect_at("reentry_pre", 4, 1, 0, 5);
      expect_at("reentry_pos6", 5, 1, 0, 6);
      expect_at("up_pos7", 9, 1, 0, 7);
      wait_n(9);

      go_up = 1'b0;
      go_down = 1'b1;
      expect_at("rev_idle", 1, 0, 0, 7);
      expect_at("rev_down", 2, 0, 1, 7);
      expect_at("rev_pre", 5, 0, 1, 7);
      expect_at("rev_pos6", 6, 0, 1, 6);
      wait_n(6);

      go_down = 1'b0;
      go_up = 1'b1;
      expect_at("rev2_idle", 1, 0, 0, 6);
      expect_at("rev2_up", 2, 1, 0, 6);
      expect_at("rev2_pos9", 14, 1, 0, 9);
      wait_n(14);
      go_up = 1'b0;
      go_down = 1'b1;
      expect_at("rev3_idle", 1, 0, 0, 9);
      expect_at("rev3_down", 2, 0, 1, 9);
      wait_n(2);

      expect_at("async_rst", 1, 0, 0, 0);
      @(posedge CLK);
      #2;
      RESET = 1'b1;
      go_down = 1'b0;
      @(negedge CLK);
      #1;
      RESET = 1'b0;
      go_up = 1'b1;
      expect_at("post_rst_up", 1, 1, 0, 0);
      wait_n(1);
      go_up = 1'b0;
      halt = 1'b1;
      expect_at("final_halt", 1, 0, 0, 0);
      wait_n(2);

      n_cmp = n_cmp + 1;
      if (q.size() != 0) begin
         n_bad = n_bad + 1;
         $display("FAIL queue_drain got %0d pending want 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

   // watchdog
   initial begin
      #100000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/hoist_ctrl.md
HOIST_CTRL -- requirements
Module: hoist_ctrl

Interface
REQ-001 Parameter: POS_MAX, 15, highest position index; the lowest position is 0.
REQ-002 Parameter: POS_W, 4, width of pos; 2^POS_W SHALL be greater than POS_MAX.
REQ-003 Parameter: STEP_CYCLES, 4, clock edges spent in a moving state per position step; minimum 1.
REQ-004 CLK  input  1  sole clock; all state SHALL change on the rising edge.
REQ-005 RESET  input  1  reset, asynchronous, active-high.
REQ-006 go_up  input  1  level request to travel up.
REQ-007 go_down  input  1  level request to travel down.
REQ-008 halt  input  1  level emergency stop; it has highest priority.
REQ-009 motor_up  output  1  drives the motor upward; Moore output, high only in MOVING_UP.
REQ-010 motor_down  output  1  drives the motor downward; Moore output, high only in MOVING_DOWN.
REQ-011 pos  output  POS_W  current position register.
REQ-012 top_lim  output  1  high when pos == POS_MAX; decoded from the pos register only.
REQ-013 bott_lim  output  1  high when pos == 0; decoded from the pos register only.

Function
REQ-014 The state machine SHALL have exactly four states: IDLE, MOVING_UP, MOVING_DOWN, HALTED.
REQ-015 From any state, halt=1 at an edge SHALL move the block to HALTED; pos SHALL be frozen and the step counter cleared.
REQ-016 In HALTED with halt=0 at an edge, the next state SHALL be IDLE, never directly a moving state.
REQ-017 In IDLE with halt=0, the next state SHALL be:
  - MOVING_UP if go_up=1, go_down=0 and pos < POS_MAX.
  - MOVING_DOWN if go_down=1, go_up=0 and pos > 0.
  - Otherwise IDLE; this includes go_up=go_down=1 and a request toward the limit already reached.
REQ-018 Step counter (width ceil(log2(STEP_CYCLES)), minimum 1) SHALL be 0 in every non-moving state and on entry to any moving state.
REQ-019 In a moving state, at each edge:
  - If step == STEP_CYCLES-1: step <= 0 and pos <= pos ±1.
  - Otherwise: step <= step+1.
  - The first pos change SHALL occur STEP_CYCLES edges after the entry edge.
REQ-020 At the edge where pos becomes POS_MAX (MOVING_UP) or 0 (MOVING_DOWN), the same edge SHALL set the state to IDLE, so the motor never drives past a limit.
REQ-021 Once moving, motion SHALL continue with the request released, until a limit, halt, or the opposite command is reached.
REQ-022 Reversal:
  - In MOVING_UP, go_down=1 with go_up=0 SHALL go to IDLE.
  - In MOVING_DOWN, go_up=1 with go_down=0 SHALL go to IDLE.
  - This gives at least one IDLE cycle of dead time before the opposite motion.
  - pos SHALL NOT step on that edge.
REQ-023 In a moving state, go_up=go_down=1 SHALL NOT interrupt motion.
REQ-024 motor_up and motor_down SHALL never be high simultaneously.
REQ-025 pos SHALL never leave the range 0..POS_MAX; no wrap-around.

Reset
REQ-026 While RESET=1, independent of CLK:
  - state=IDLE, pos=0, step=0.
  - motor_up=0, motor_down=0, top_lim=0, bott_lim=1.
REQ-027 RESET asserted mid-motion SHALL abort motion immediately, with no completion of a pending step.
REQ-028 After RESET falls, the first edge SHALL evaluate REQ-015..REQ-017 normally.

Verification (POS_MAX=15, STEP_CYCLES=4)
REQ-029 Pulse RESET with go_up=1 -> during reset pos=0, bott_lim=1, motors=0; after release, motor_up=1 after one edge.
REQ-030 Hold go_up from pos 0 -> the entry edge is k; pos=1 at edge k+4 and pos=15 at edge k+60; at edge k+60 top_lim=1 and motor_up=0 in the same cycle.
REQ-031 Boundary requests:
  - At pos 0, go_down=1 -> stays IDLE, pos=0.
  - At pos 15, go_up=1 -> stays IDLE.
  - go_up=go_down=1 in IDLE -> stays IDLE.
REQ-032 Halt mid-travel:
  - halt=1 during MOVING_UP at pos 5, step 2 -> HALTED next edge, pos=5, motors=0.
  - Release halt -> IDLE.
  - Then go_up -> pos=6 four edges after re-entry to MOVING_UP.
REQ-033 Reversal at pos 7 in MOVING_UP with go_down=1, go_up=0:
  - IDLE for exactly one cycle, then MOVING_DOWN.
  - pos=6 four edges after that entry; motor outputs never overlap.
REQ-034 Assert RESET asynchronously between edges while MOVING_DOWN at pos 9 -> pos=0, motors=0 before the next CLK edge.
